// File: rtl/rsa_modexp_core.sv
// ---------------------------------------------------------------------------
// rsa_modexp_core
//
// Computes RES = M^E mod N with bit-serial Montgomery square-and-multiply.
// The operands sit in byte-addressable registers behind a simple host port.
// A run is requested with a one-cycle start and reports back through the
// busy, done and err handshake outputs.
//
// Parameters:
//   WIDTH   operand width in bits (a multiple of DATA_W, at least 16)
//   DATA_W  host data bus width
//   AW      byte-lane address width (derived from WIDTH and DATA_W)
//
// Ports:
//   clk      system clock, rising edge
//   reset_n  asynchronous active-low reset
//   wr_en    host write strobe; ignored while busy or when reg_sel = 0
//   rd_en    host read strobe; data_o updates on the next edge
//   reg_sel  0 = RES (read-only), 1 = M, 2 = E, 3 = N
//   addr     byte lane within the selected register
//   data_i   host write data
//   data_o   registered host read data
//   start    run request, sampled only in IDLE
//   busy     high while a run is in progress
//   done     one-cycle completion pulse
//   err      sticky flag for a rejected run, cleared by the next start
// ---------------------------------------------------------------------------
module rsa_modexp_core #(
    parameter int WIDTH  = 256,
    parameter int DATA_W = 8,
    parameter int AW     = $clog2(WIDTH / DATA_W)
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              wr_en,
    input  logic              rd_en,
    input  logic [1:0]        reg_sel,
    input  logic [AW-1:0]     addr,
    input  logic [DATA_W-1:0] data_i,
    output logic [DATA_W-1:0] data_o,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam int LANES = WIDTH / DATA_W;
    localparam int ACC_W = WIDTH + 2;
    localparam int CW    = $clog2(2 * WIDTH);
    localparam int RW    = $clog2(WIDTH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PRE,
        S_TOMONT,
        S_EXP,
        S_FROMMONT,
        S_DONE,
        S_ERR
    } state_t;

    state_t state, next_state;

    logic [WIDTH-1:0]  m_reg, e_reg, n_reg, res_reg;
    logic [WIDTH-1:0]  a_reg, t_reg;
    logic [WIDTH-1:0]  xs0, xs1;
    logic [ACC_W-1:0]  acc0, acc1;
    logic [CW-1:0]     cnt;
    logic [RW-1:0]     round;

    logic [WIDTH-1:0]  y0;
    logic [ACC_W-1:0]  n_ext, sum0, sum1, step0, step1;
    logic [WIDTH-1:0]  result0, result1;
    logic [WIDTH:0]    dbl;
    logic [WIDTH-1:0]  pre_next;
    logic              operands_bad, mm_last, pre_last, round_last;
    logic [WIDTH-1:0]  rd_word;
    logic [DATA_W-1:0] rd_lane;

    // Datapath arithmetic. Engine 0 computes MM(xs0, y0) and engine 1
    // computes MM(xs1, T); X is consumed LSB first from a shift register
    // while Y stays constant for the whole multiply.
    always_comb begin
        operands_bad = ~n_reg[0] | (n_reg <= WIDTH'(1)) | (m_reg >= n_reg);
        mm_last      = (cnt == CW'(WIDTH));
        pre_last     = (cnt == CW'(2 * WIDTH - 1));
        round_last   = (round == RW'(WIDTH - 1));

        y0 = t_reg;
        if (state == S_FROMMONT) begin
            y0 = WIDTH'(1);
        end
        n_ext = {2'b00, n_reg};

        // q is the LSB of T + X[i]*Y; adding q*N makes the sum even
        sum0  = acc0 + (xs0[0] ? {2'b00, y0} : {ACC_W{1'b0}});
        step0 = (sum0 + (sum0[0] ? n_ext : {ACC_W{1'b0}})) >> 1;
        sum1  = acc1 + (xs1[0] ? {2'b00, t_reg} : {ACC_W{1'b0}});
        step1 = (sum1 + (sum1[0] ? n_ext : {ACC_W{1'b0}})) >> 1;

        // After WIDTH iterations T < 2N, so one conditional subtract suffices
        result0 = (acc0 >= n_ext) ? WIDTH'(acc0 - n_ext) : WIDTH'(acc0);
        result1 = (acc1 >= n_ext) ? WIDTH'(acc1 - n_ext) : WIDTH'(acc1);

        // Modular doubling used to build R mod N and R^2 mod N
        dbl      = {t_reg, 1'b0};
        pre_next = (dbl >= {1'b0, n_reg}) ? WIDTH'(dbl - {1'b0, n_reg}) : WIDTH'(dbl);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        busy       = 1'b1;
        case (state)
            S_IDLE: begin
                busy = 1'b0;
                if (start) begin
                    next_state = operands_bad ? S_ERR : S_PRE;
                end
            end
            S_PRE: begin
                if (pre_last) next_state = S_TOMONT;
            end
            S_TOMONT: begin
                if (mm_last) next_state = S_EXP;
            end
            S_EXP: begin
                if (mm_last && round_last) next_state = S_FROMMONT;
            end
            S_FROMMONT: begin
                if (mm_last) next_state = S_DONE;
            end
            S_DONE: begin
                busy       = 1'b0;
                next_state = S_IDLE;
            end
            S_ERR: begin
                next_state = S_IDLE;
            end
            default: begin
                next_state = S_IDLE;
            end
        endcase
    end

    // Sequencing of the exponentiation datapath. T doubles as the C register
    // during precomputation, so TOMONT reads R^2 mod N straight from it.
    // done is registered: it rises together with the DONE state on the main
    // path, and on the cycle after ERR for a rejected run.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            res_reg <= '0;
            a_reg   <= '0;
            t_reg   <= '0;
            xs0     <= '0;
            xs1     <= '0;
            acc0    <= '0;
            acc1    <= '0;
            cnt     <= '0;
            round   <= '0;
            done    <= 1'b0;
            err     <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    cnt <= '0;
                    if (start) begin
                        err <= 1'b0;
                        if (!operands_bad) begin
                            res_reg <= '0;
                            t_reg   <= WIDTH'(1);
                        end
                    end
                end
                S_PRE: begin
                    t_reg <= pre_next;
                    if (cnt == CW'(WIDTH - 1)) begin
                        a_reg <= pre_next;
                    end
                    if (pre_last) begin
                        cnt  <= '0;
                        xs0  <= m_reg;
                        acc0 <= '0;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                S_TOMONT: begin
                    if (mm_last) begin
                        t_reg <= result0;
                        xs0   <= a_reg;
                        xs1   <= result0;
                        acc0  <= '0;
                        acc1  <= '0;
                        cnt   <= '0;
                        round <= '0;
                    end else begin
                        acc0 <= step0;
                        xs0  <= xs0 >> 1;
                        cnt  <= cnt + CW'(1);
                    end
                end
                S_EXP: begin
                    if (mm_last) begin
                        t_reg <= result1;
                        xs1   <= result1;
                        if (e_reg[round]) begin
                            a_reg <= result0;
                            xs0   <= result0;
                        end else begin
                            xs0 <= a_reg;
                        end
                        acc0  <= '0;
                        acc1  <= '0;
                        cnt   <= '0;
                        round <= round + RW'(1);
                    end else begin
                        acc0 <= step0;
                        acc1 <= step1;
                        xs0  <= xs0 >> 1;
                        xs1  <= xs1 >> 1;
                        cnt  <= cnt + CW'(1);
                    end
                end
                S_FROMMONT: begin
                    if (mm_last) begin
                        res_reg <= result0;
                        done    <= 1'b1;
                        cnt     <= '0;
                    end else begin
                        acc0 <= step0;
                        xs0  <= xs0 >> 1;
                        cnt  <= cnt + CW'(1);
                    end
                end
                S_DONE: begin
                end
                S_ERR: begin
                    res_reg <= '0;
                    err     <= 1'b1;
                    done    <= 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

    always_comb begin
        case (reg_sel)
            2'd0:    rd_word = res_reg;
            2'd1:    rd_word = m_reg;
            2'd2:    rd_word = e_reg;
            default: rd_word = n_reg;
        endcase
        rd_lane = '0;
        for (int k = 0; k < LANES; k++) begin
            if (addr == AW'(k)) begin
                rd_lane = rd_word[k*DATA_W +: DATA_W];
            end
        end
    end

    // Host register port; operands are frozen while a run is in progress
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_reg  <= '0;
            e_reg  <= '0;
            n_reg  <= '0;
            data_o <= '0;
        end else begin
            if (wr_en && !busy) begin
                for (int k = 0; k < LANES; k++) begin
                    if (addr == AW'(k)) begin
                        case (reg_sel)
                            2'd1:    m_reg[k*DATA_W +: DATA_W] <= data_i;
                            2'd2:    e_reg[k*DATA_W +: DATA_W] <= data_i;
                            2'd3:    n_reg[k*DATA_W +: DATA_W] <= data_i;
                            default: ;
                        endcase
                    end
                end
            end
            if (rd_en) begin
                data_o <= rd_lane;
            end
        end
    end

endmodule
